// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Byte stream to 32-bit word assembly at boot or via debug.
package instr_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_WIDTH     = 8;
    localparam int WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;
    localparam int INDEX_WIDTH    = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian byte lane packer: first byte lands in [7:0].
// word_full flags that the next accepted byte completes the word.
module byte_word_assembler
    import instr_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word_next,
    output logic                  word_full
);

    logic [INDEX_WIDTH-1:0] idx;
    logic [WORD_WIDTH-1:0]  lanes;

    // Current lanes with the incoming byte dropped into its slot.
    always_comb begin
        word_next = lanes;
        word_next[idx*BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
    end

    assign word_full = (idx == INDEX_WIDTH'(BYTES_PER_WORD - 1));

    // Lane index and partial word; index rolls over after the last lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            lanes <= '0;
        end else if (clear) begin
            idx   <= '0;
            lanes <= '0;
        end else if (accept) begin
            idx   <= idx + 1'b1;
            lanes <= word_next;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program into instruction memory one word at a time.
// Busy holds the core off while a session is in progress.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 9,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int COUNT_WIDTH       = ADDRESS_WIDTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Start,
    input  logic [ADDRESS_WIDTH-1:0]     BaseAddress,
    input  logic [COUNT_WIDTH-1:0]       WordCount,
    input  logic [BYTE_WIDTH-1:0]        ByteIn,
    input  logic                         ByteValid,
    output logic                         ByteReady,
    output logic [ADDRESS_WIDTH-1:0]     WriteAddress,
    output logic [INSTRUCTION_WIDTH-1:0] WriteData,
    output logic                         WriteEnable,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Wrapped
);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic [ADDRESS_WIDTH:0]   addr_sum;
    logic [ADDRESS_WIDTH-1:0] base_aligned;
    logic [WORD_WIDTH-1:0]    word_next;
    logic                     word_full;
    logic                     take;
    logic                     clear;

    assign take         = ByteValid && ByteReady;
    assign clear        = (state == IDLE) && Start;
    assign addr_sum     = {1'b0, addr} + (ADDRESS_WIDTH+1)'(BYTES_PER_WORD);
    assign base_aligned = BaseAddress & ~ADDRESS_WIDTH'(BYTES_PER_WORD - 1);

    byte_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .accept    (take),
        .byte_in   (ByteIn),
        .word_next (word_next),
        .word_full (word_full)
    );

    // Session FSM with address/count tracking and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            ByteReady    <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
            WriteEnable  <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Wrapped      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        Wrapped <= 1'b0;
                        if (WordCount != '0) begin
                            state     <= COLLECT;
                            addr      <= base_aligned;
                            remaining <= WordCount;
                            ByteReady <= 1'b1;
                            Busy      <= 1'b1;
                        end else begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (take && word_full) begin
                        state        <= WRITE;
                        ByteReady    <= 1'b0;
                        WriteEnable  <= 1'b1;
                        WriteAddress <= addr;
                        WriteData    <= INSTRUCTION_WIDTH'(word_next);
                    end
                end
                WRITE: begin
                    WriteEnable <= 1'b0;
                    addr        <= addr_sum[ADDRESS_WIDTH-1:0];
                    remaining   <= remaining - 1'b1;
                    if (addr_sum[ADDRESS_WIDTH]) begin
                        Wrapped <= 1'b1;
                    end
                    if (remaining == COUNT_WIDTH'(1)) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        state     <= COLLECT;
                        ByteReady <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued
// by the stimulus and popped by a negedge monitor on WriteEnable.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [8:0]  BaseAddress = '0;
    logic [7:0]  WordCount = '0;
    logic [7:0]  ByteIn = '0;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic [8:0]  WriteAddress;
    logic [31:0] WriteData;
    logic        WriteEnable;
    logic        Busy;
    logic        Done;
    logic        Wrapped;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  we_cyc[$];
    int  done_cyc = -1;
    int  dones = 0;
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    instr_mem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Start        (Start),
        .BaseAddress  (BaseAddress),
        .WordCount    (WordCount),
        .ByteIn       (ByteIn),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .WriteEnable  (WriteEnable),
        .Busy         (Busy),
        .Done         (Done),
        .Wrapped      (Wrapped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (WriteEnable) begin
                we_cyc.push_back(cyc);
                chk("ready_low_in_write", 32'(ByteReady), 32'd0);
                chk("busy_in_write", 32'(Busy), 32'd1);
                chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(WriteAddress), 32'(e.a));
                    chk("wr_data", WriteData, e.d);
                end
            end
            if (Done) begin
                dones++;
                done_cyc = cyc;
            end
        end
    end

    task automatic expect_wr(input logic [8:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic start(input logic [8:0] b, input logic [7:0] c);
        Start = 1'b1;
        BaseAddress = b;
        WordCount = c;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        ByteValid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        ByteValid = 1'b1;
        ByteIn = b;
        n = 0;
        while (ByteReady !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("ready_wait_bound", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        ByteValid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (Done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait_bound", 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a partial word.
        start(9'h040, 8'd2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ByteReady), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_we", 32'(WriteEnable), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_wrapped", 32'(Wrapped), 32'd0);
        chk("rst_addr", 32'(WriteAddress), 32'd0);
        chk("rst_data", WriteData, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word after reset.
        d0 = dones;
        expect_wr(9'h010, 32'h00500013);
        start(9'h010, 8'd1);
        chk("busy_collect", 32'(Busy), 32'd1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        wait_done();
        chk("single_dones", 32'(dones - d0), 32'd1);

        // Multi-word from a misaligned base, back-to-back bytes.
        we_cyc.delete();
        expect_wr(9'h020, 32'h04030201);
        expect_wr(9'h024, 32'h08070605);
        expect_wr(9'h028, 32'h0C0B0A09);
        start(9'h023, 8'd3);
        for (int i = 1; i <= 12; i++) send_byte(8'(i), 0);
        wait_done();
        chk("multi_we_count", 32'(we_cyc.size()), 32'd3);
        if (we_cyc.size() == 3) begin
            chk("multi_gap0", 32'(we_cyc[1] - we_cyc[0]), 32'd5);
            chk("multi_gap1", 32'(we_cyc[2] - we_cyc[1]), 32'd5);
            chk("multi_done_lat", 32'(done_cyc - we_cyc[2]), 32'd1);
        end

        // Same data with random valid gaps.
        we_cyc.delete();
        expect_wr(9'h020, 32'h04030201);
        expect_wr(9'h024, 32'h08070605);
        expect_wr(9'h028, 32'h0C0B0A09);
        start(9'h023, 8'd3);
        for (int i = 1; i <= 12; i++) send_byte(8'(i), int'($urandom_range(0, 3)));
        wait_done();
        chk("gap_we_count", 32'(we_cyc.size()), 32'd3);

        // Zero count: immediate Done, never busy, no write.
        we_cyc.delete();
        d0 = dones;
        ByteValid = 1'b1;
        start(9'h040, 8'd0);
        chk("zero_done", 32'(Done), 32'd1);
        chk("zero_busy", 32'(Busy), 32'd0);
        chk("zero_ready", 32'(ByteReady), 32'd0);
        @(posedge clk);
        #1;
        chk("zero_done_fall", 32'(Done), 32'd0);
        chk("zero_busy_idle", 32'(Busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        ByteValid = 1'b0;
        chk("zero_no_write", 32'(we_cyc.size()), 32'd0);
        chk("zero_dones", 32'(dones - d0), 32'd1);

        // Start pulsed mid-session must be ignored.
        we_cyc.delete();
        expect_wr(9'h080, 32'h13121110);
        expect_wr(9'h084, 32'h17161514);
        start(9'h080, 8'd2);
        send_byte(8'h10, 0);
        send_byte(8'h11, 0);
        start(9'h100, 8'd5);
        for (int i = 2; i < 8; i++) send_byte(8'(8'h10 + i), 0);
        wait_done();
        chk("ign_we_count", 32'(we_cyc.size()), 32'd2);
        chk("ign_idle_busy", 32'(Busy), 32'd0);

        // Wrap past the top of memory.
        expect_wr(9'h1FC, 32'hDDCCBBAA);
        expect_wr(9'h000, 32'h44332211);
        start(9'h1FC, 8'd2);
        chk("wrap_clear_start", 32'(Wrapped), 32'd0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        chk("wrap_before_write", 32'(Wrapped), 32'd0);
        @(posedge clk);
        #1;
        chk("wrap_after_first", 32'(Wrapped), 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_held_idle", 32'(Wrapped), 32'd1);
        start(9'h000, 8'd0);
        chk("wrap_cleared", 32'(Wrapped), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory.
- Receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and issues single-cycle word writes toward the Memory32 write port (WriteAddress/DataIn/WriteEnable).
- Used at boot or by the debug path to load code before the core fetches.
- Asserts Busy while loading so the core is held off.

Parameters:
- ADDRESS_WIDTH, 9, byte-address width of instruction memory; matches the fetch-side address.
- INSTRUCTION_WIDTH, 32, word width; fixed at 4 bytes per word.
- COUNT_WIDTH, ADDRESS_WIDTH-1, width of the word-count input. Holds 0..2^(ADDRESS_WIDTH-2) words, full memory inclusive.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to begin a load session; ignored unless IDLE.
- BaseAddress  input  ADDRESS_WIDTH  byte start address, sampled on Start; low 2 bits forced to 0.
- WordCount  input  COUNT_WIDTH  number of words to load, sampled on Start.
- ByteIn  input  8  stream data byte.
- ByteValid  input  1  stream byte valid.
- ByteReady  output  1  loader accepts a byte this cycle.
- WriteAddress  output  ADDRESS_WIDTH  byte address of the word write.
- WriteData  output  INSTRUCTION_WIDTH  assembled instruction.
- WriteEnable  output  1  one-cycle write strobe.
- Busy  output  1  session in progress.
- Done  output  1  one-cycle pulse at session end.
- Wrapped  output  1  sticky; address wrapped past top of memory this session.

Behaviour:
- Reset (async assert, sync-safe release):
  - State IDLE.
  - All outputs 0; address, count, byte index and partial word cleared.
  - Reset mid-session discards any partial word and issues no write.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: ByteReady=0, Busy=0.
  - Start with WordCount≠0 → COLLECT. Load addr={BaseAddress[AW-1:2],2'b00}, remaining=WordCount, byte index=0. Clear Wrapped.
  - Start with WordCount=0 → DONE directly, no writes. Clear Wrapped.
- COLLECT: ByteReady=1, Busy=1.
  - Each handshake (ByteValid&&ByteReady at a rising edge) stores ByteIn into lane index (first byte → [7:0], fourth → [31:24]) and increments the index.
  - ByteValid low → state holds, no timeout.
  - Acceptance of the 4th byte → WRITE, index back to 0.
- WRITE: exactly one cycle. ByteReady=0, Busy=1, WriteEnable=1, WriteAddress=addr, WriteData=assembled word.
  - At the edge: addr ← addr+4 modulo 2^ADDRESS_WIDTH; if the add carries out, Wrapped←1.
  - remaining ← remaining−1. Result 0 → DONE, else COLLECT.
- DONE: Done=1 for one cycle, Busy=0, ByteReady=0; → IDLE.
- Outside WRITE: WriteEnable=0, WriteAddress and WriteData hold their last values.
- Latency:
  - 4th-byte handshake at edge N → WriteEnable high during cycle N..N+1.
  - Final WRITE cycle followed immediately by the Done cycle.
  - Peak throughput: 1 word per 5 cycles.
- Start while not IDLE: ignored, no effect on sampled values.
- ByteValid asserted in IDLE/WRITE/DONE: no handshake, byte not consumed.
- Wrap-around: session continues writing from address 0; Wrapped stays high until the next Start or reset.
- WordCount = 2^(ADDRESS_WIDTH-2) from base 0: fills memory exactly. Final addr increment wraps to 0 and sets Wrapped.

Decomposition:
- Package instr_loader_pkg:
  - state enum (IDLE, COLLECT, WRITE, DONE).
  - BYTES_PER_WORD=4.
  - BYTE_WIDTH=8.
- Sub-module byte_word_assembler: byte index counter plus lane register; accept/clear inputs, word_full output.
- FSM, address counter and remaining counter stay in the top.

Test Plan:
- Reset values: rst_n low mid-COLLECT after 2 bytes → all outputs 0 immediately. After release, Start with BaseAddress=0x010, WordCount=1, bytes 13,00,50,00 → one write, addr 0x010, data 0x00500013.
- Multi-word: BaseAddress=0x023 (misaligned), WordCount=3, 12 bytes continuous → writes at 0x020, 0x024, 0x028. WriteEnable high exactly 3 cycles, 5 cycles apart. Done 1 cycle after the last write.
- Backpressure/gaps: ByteValid toggled randomly → same data and addresses as the gap-free run; no byte dropped or duplicated; ByteReady=0 during WRITE.
- Zero count: Start, WordCount=0 → Done pulses next cycle, WriteEnable never asserts, Busy stays 0.
- Wrap: BaseAddress=0x1FC, WordCount=2 → writes at 0x1FC then 0x000. Wrapped=1 after the first write and held through IDLE; cleared by the next Start.
- Ignored Start: Start pulsed mid-session with different BaseAddress/WordCount → original session completes unchanged.
